// File: rtl/alu_multicycle_pkg.sv
// Opcode and FSM encodings for the multi-cycle ALU, shared with the control unit's ALU decoder.
// Optional divider is enabled with the ALU_MULTICYCLE_DIV_EN macro (see alu_multicycle.sv).
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_SLT  = 3'b100;
    localparam logic [2:0] OP_SLTU = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_DIV  = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/result bundle between the control FSM (master) and the multi-cycle ALU (slave).
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic [2:0]       i_sel;
    logic [WIDTH-1:0] i_op1;
    logic [WIDTH-1:0] i_op2;
    logic             o_ready;
    logic             o_valid;
    logic [WIDTH-1:0] ALUresult;
    logic [WIDTH-1:0] o_hi;
    logic             Zero;

    modport master (
        output i_valid, i_sel, i_op1, i_op2,
        input  o_ready, o_valid, ALUresult, o_hi, Zero
    );

    modport slave (
        input  i_valid, i_sel, i_op1, i_op2,
        output o_ready, o_valid, ALUresult, o_hi, Zero
    );
endinterface

// File: rtl/alu_multicycle_iter_core.sv
// Iterative datapath: shift-add multiplier and (with ALU_MULTICYCLE_DIV_EN) restoring divider.
// Exposes next-step values so the caller can capture the final iteration on the same edge.
module alu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             load_s,
    input  logic             step_s,
    input  logic             div_s,
    input  logic [WIDTH-1:0] op1_s,
    input  logic [WIDTH-1:0] op2_s,
    output logic [WIDTH-1:0] lo_nxt_s,
    output logic [WIDTH-1:0] hi_nxt_s
);

    // a_r: multiplicand or divisor; hi_r: partial product high half or remainder;
    // lo_r: multiplier being consumed or dividend shifting into the quotient.
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] mul_hi_s;
    logic [WIDTH-1:0] mul_lo_s;

    // One shift-add multiplier step
    always_comb begin
        sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        mul_hi_s = sum_s[WIDTH:1];
        mul_lo_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end

`ifdef ALU_MULTICYCLE_DIV_EN
    logic             div_mode_r;
    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] div_hi_s;
    logic [WIDTH-1:0] div_lo_s;

    // One restoring-division step; a zero divisor naturally yields all-ones quotient
    // and the dividend as remainder
    always_comb begin
        shifted_s = {hi_r, lo_r[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, a_r});
        if (ge_s) begin
            div_hi_s = WIDTH'(shifted_s - {1'b0, a_r});
        end else begin
            div_hi_s = shifted_s[WIDTH-1:0];
        end
        div_lo_s = {lo_r[WIDTH-2:0], ge_s};
    end

    // Latch the operating mode with the operands
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_mode_r <= 1'b0;
        end else if (load_s) begin
            div_mode_r <= div_s;
        end else begin
            div_mode_r <= div_mode_r;
        end
    end

    // Select the active datapath
    always_comb begin
        if (div_mode_r) begin
            hi_nxt_s = div_hi_s;
            lo_nxt_s = div_lo_s;
        end else begin
            hi_nxt_s = mul_hi_s;
            lo_nxt_s = mul_lo_s;
        end
    end
`else
    logic unused_div_s;
    assign unused_div_s = div_s;

    // Multiplier is the only iterative operation
    always_comb begin
        hi_nxt_s = mul_hi_s;
        lo_nxt_s = mul_lo_s;
    end
`endif

    // Working registers: load operands on accept, advance one step per enable
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            a_r  <= {WIDTH{1'b0}};
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (load_s) begin
            a_r  <= div_s ? op2_s : op1_s;
            hi_r <= {WIDTH{1'b0}};
            lo_r <= div_s ? op1_s : op2_s;
        end else if (step_s) begin
            a_r  <= a_r;
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end else begin
            a_r  <= a_r;
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle MIPS ALU: single-cycle logic/arith ops plus iterative MUL and optional DIV
// behind a valid/ready handshake. Define ALU_MULTICYCLE_DIV_EN to build the divider.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    alu_multicycle_if.slave   bus
);

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] hi_r;
    logic             zero_r;

    logic             accept_s;
    logic             is_mul_s;
    logic             is_div_s;
    logic             iter_op_s;
    logic             last_step_s;
    logic [WIDTH-1:0] single_s;
    logic [WIDTH-1:0] core_lo_s;
    logic [WIDTH-1:0] core_hi_s;

    assign accept_s    = bus.i_valid && (state_r == ST_IDLE);
    assign is_mul_s    = (bus.i_sel == OP_MUL);
`ifdef ALU_MULTICYCLE_DIV_EN
    assign is_div_s    = (bus.i_sel == OP_DIV);
`else
    assign is_div_s    = 1'b0;
`endif
    assign iter_op_s   = is_mul_s || is_div_s;
    assign last_step_s = (state_r == ST_BUSY) && (cnt_r == CNT_W'(WIDTH - 1));

    // Single-cycle results; MUL, and DIV when the divider is absent, fall to zero
    always_comb begin
        single_s = {WIDTH{1'b0}};
        case (bus.i_sel)
            OP_ADD:  single_s = bus.i_op1 + bus.i_op2;
            OP_SUB:  single_s = bus.i_op1 - bus.i_op2;
            OP_AND:  single_s = bus.i_op1 & bus.i_op2;
            OP_OR:   single_s = bus.i_op1 | bus.i_op2;
            OP_SLT:  single_s = {{(WIDTH-1){1'b0}}, ($signed(bus.i_op1) < $signed(bus.i_op2))};
            OP_SLTU: single_s = {{(WIDTH-1){1'b0}}, (bus.i_op1 < bus.i_op2)};
            default: single_s = {WIDTH{1'b0}};
        endcase
    end

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter_core (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .load_s   (accept_s && iter_op_s),
        .step_s   (state_r == ST_BUSY),
        .div_s    (is_div_s),
        .op1_s    (bus.i_op1),
        .op2_s    (bus.i_op2),
        .lo_nxt_s (core_lo_s),
        .hi_nxt_s (core_hi_s)
    );

    // Control FSM and iteration counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (accept_s) begin
                        state_r <= iter_op_s ? ST_BUSY : ST_DONE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (last_step_s) begin
                        state_r <= ST_DONE;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= ST_BUSY;
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Result registers change only on the edge that enters DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            result_r <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            zero_r   <= 1'b1;
        end else if (accept_s && !iter_op_s) begin
            result_r <= single_s;
            hi_r     <= {WIDTH{1'b0}};
            zero_r   <= (single_s == {WIDTH{1'b0}});
        end else if (last_step_s) begin
            result_r <= core_lo_s;
            hi_r     <= core_hi_s;
            zero_r   <= (core_lo_s == {WIDTH{1'b0}});
        end else begin
            result_r <= result_r;
            hi_r     <= hi_r;
            zero_r   <= zero_r;
        end
    end

    assign bus.o_ready   = (state_r == ST_IDLE);
    assign bus.o_valid   = (state_r == ST_DONE);
    assign bus.ALUresult = result_r;
    assign bus.o_hi      = hi_r;
    assign bus.Zero      = zero_r;

endmodule
